// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths and the writeback slot record for the register-file writeback path.
// The writeback arbiter and its neighbours all import this package.
package regfile_wb_arbiter_pkg;

   localparam int XLEN         = 32;
   localparam int AW           = 5;
   localparam int NREQ_DEFAULT = 3;

   typedef struct packed {
      logic            valid;
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data;
   } wb_slot_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Round-robin picker: the first set request at or after ptr_i, wrapping at N-1 -> 0.
// Produces a one-hot grant vector and the binary index of the winner.
module rr_arbiter #(
   parameter int N  = 3,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);

   always_comb begin
      int k;
      k     = 0;
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      for (int off = 0; off < N; off++) begin
         // ptr_i is always below N, so one subtraction is enough to wrap
         k = int'(ptr_i) + off;
         if (k >= N) k = k - N;
         if (!any_o && req_i[k]) begin
            any_o    = 1'b1;
            gnt_o[k] = 1'b1;
            idx_o    = IW'(k);
         end
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: one holding slot per requester, drained one write per cycle
// into the register file write port in round-robin order.
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int NREQ = NREQ_DEFAULT,
   parameter int XLEN = regfile_wb_arbiter_pkg::XLEN,
   parameter int AW   = regfile_wb_arbiter_pkg::AW,
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic [NREQ-1:0]           req_valid,
   output logic [NREQ-1:0]           req_ready,
   input  logic [NREQ-1:0][AW-1:0]   req_addr,
   input  logic [NREQ-1:0][XLEN-1:0] req_data,
   output logic                      we3,
   output logic [AW-1:0]             a3,
   output logic [XLEN-1:0]           wd3,
   output logic [(1<<AW)-1:0]        pending,
   output logic [IDW-1:0]            grant_id
);

   typedef struct packed {
      logic            valid;
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data;
   } slot_t;

   slot_t           slot_q [NREQ];
   slot_t           slot_d [NREQ];
   logic [IDW-1:0]  ptr_q, ptr_d;
   logic [NREQ-1:0] occ, gnt;
   logic [IDW-1:0]  gidx;
   logic            gany, wr_en;

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_slot
         assign occ[gi]       = slot_q[gi].valid;
         assign req_ready[gi] = !flush & (!slot_q[gi].valid | gnt[gi]);
      end
   endgenerate

   rr_arbiter #(.N(NREQ), .IW(IDW)) u_rr (
      .req_i (occ),
      .ptr_i (ptr_q),
      .gnt_o (gnt),
      .idx_o (gidx),
      .any_o (gany)
   );

   // Flush suppresses the write and leaves the pointer where it was
   assign wr_en    = gany & !flush;
   assign we3      = wr_en;
   assign a3       = wr_en ? slot_q[gidx].addr : '0;
   assign wd3      = wr_en ? slot_q[gidx].data : '0;
   assign grant_id = wr_en ? gidx : '0;

   always_comb begin
      for (int s = 0; s < NREQ; s++) begin
         slot_d[s] = slot_q[s];
         if (flush)
            slot_d[s].valid = 1'b0;
         else if (req_valid[s] && req_ready[s] && req_addr[s] != '0)
            slot_d[s] = '{valid: 1'b1, addr: req_addr[s], data: req_data[s]};
         else if (gnt[s])
            slot_d[s].valid = 1'b0;
      end
      if (wr_en)
         ptr_d = (gidx == IDW'(NREQ - 1)) ? '0 : gidx + 1'b1;
      else
         ptr_d = ptr_q;
   end

   always_comb begin
      pending = '0;
      for (int s = 0; s < NREQ; s++)
         if (slot_q[s].valid) pending[slot_q[s].addr] = 1'b1;
      pending[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int s = 0; s < NREQ; s++) slot_q[s] <= '0;
         ptr_q <= '0;
      end else begin
         for (int s = 0; s < NREQ; s++) slot_q[s] <= slot_d[s];
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 3, number of writeback requesters (2..8).
REQ-002 SHALL have parameter XLEN, default 32, data width.
REQ-003 SHALL have parameter AW, default 5, register address width.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  synchronous discard of all held writes.
REQ-007 req_valid  input  NREQ  per-requester write request.
REQ-008 req_ready  output  NREQ  per-requester accept indication.
REQ-009 req_addr  input  NREQ x AW  per-requester destination register.
REQ-010 req_data  input  NREQ x XLEN  per-requester write data.
REQ-011 we3  output  1  register file write enable.
REQ-012 a3  output  AW  register file write address.
REQ-013 wd3  output  XLEN  register file write data.
REQ-014 pending  output  2^AW  bitmap of registers with a held, not yet written value.
REQ-015 grant_id  output  clog2(NREQ)  index of requester whose slot drives the write port this cycle.

Function
REQ-016 SHALL hold one slot per requester (valid bit, addr, data).
REQ-017 Handshake: transfer when req_valid[i] & req_ready[i] at a rising edge. After req_valid rises, req_addr/req_data are stable until the transfer.
REQ-018 req_ready[i] = !flush & (slot i empty | slot i granted this cycle). Back-to-back transfers at one per cycle per requester.
REQ-019 Transfer with req_addr = 0 SHALL be accepted and discarded; slot unchanged, no write.
REQ-020 Each cycle, among occupied slots, exactly one is granted round-robin.
- Search starts at index ptr, ascending, wrapping at NREQ-1 -> 0.
REQ-021 When a grant exists: we3=1, a3/wd3 = granted slot contents, grant_id = its index, all driven combinationally from registered slots. Slot clears at next edge; ptr <= grant_id+1 mod NREQ.
REQ-022 No occupied slot: we3=0, a3=0, wd3=0, grant_id=0, ptr unchanged.
REQ-023 Latency: transfer at edge k -> we3 earliest in cycle following edge k -> register file updated at edge k+1.
REQ-024 Slot granted and refilled by the same requester in one cycle: old contents written, new contents captured at the same edge.
REQ-025 pending[r] = 1 iff some occupied slot holds addr r; pending[0] always 0.
REQ-026 Two slots with the same addr are both written, in grant order; the later grant is final.
REQ-027 flush=1: all slots cleared at next edge, all req_ready=0, we3=0, ptr unchanged; no transfer that cycle.
REQ-028 At most one write per cycle. No write lost except by flush or an x0 address.

Reset
REQ-029 reset low: all slots empty, ptr=0; we3=0, a3=0, wd3=0, pending=0, grant_id=0 immediately, independent of clk.
REQ-030 Reset asserted mid-operation discards held writes. First transfer is possible at the first edge after reset release.

Structure
REQ-031 A shared package SHALL hold XLEN, AW, the default NREQ, and a wb_slot_t struct {valid, addr, data}.
REQ-032 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req vector and ptr, outputs one-hot grant and index).
REQ-033 Top level SHALL hold slots, ptr, handshake, and pending decode. It is instantiated beside regfile, with we3/a3/wd3 connected directly.

Verification
REQ-034 Single: req0 addr=5 data=0xDEADBEEF -> next cycle we3=1 a3=5 wd3=0xDEADBEEF grant_id=0, pending[5]=1 that cycle, 0 after.
REQ-035 Contention: all three valid in the same cycle (addr 1,2,3), ptr=0 -> writes in order 1,2,3 on three consecutive cycles. req1/req2 ready stays high only after their slot drains.
REQ-036 Fairness: req0 and req2 continuously valid for 10 cycles -> grants alternate 0,2,0,2. Neither slot waits more than NREQ-1 cycles.
REQ-037 x0: req1 addr=0 data=0x1234 -> req_ready=1, no we3, pending=0.
REQ-038 Flush: slots 0,1 occupied, flush=1 for one cycle -> we3=0 that cycle, slots empty after, no later write of those values.
REQ-039 Async reset: reset low between edges with slots full -> outputs zero immediately. After release, first write appears only after a new transfer.
